// File: rtl/uart_rx_core_if.sv
// Byte-level handshake between the UART receiver core and the UART
// Wishbone control block. The receiver drives the byte and status flags.
// The control block answers with a one-cycle "read finished" pulse.
interface uart_rx_core_if;
  logic [31:0] o_rx;           // received byte in [7:0], upper bits zero
  logic        o_send_signal;  // level: valid byte pending
  logic        o_irq;          // one-cycle pulse per good frame
  logic        o_rx_busy;      // frame reception in progress
  logic        o_frame_err;    // level: last frame had a low stop bit
  logic        i_rx_finish;    // pulse: pending byte or error consumed

  // Receiver side
  modport master (
    output o_rx,
    output o_send_signal,
    output o_irq,
    output o_rx_busy,
    output o_frame_err,
    input  i_rx_finish
  );

  // Control-block side
  modport slave (
    input  o_rx,
    input  o_send_signal,
    input  o_irq,
    input  o_rx_busy,
    input  o_frame_err,
    output i_rx_finish
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver, 8N1, LSB first.
// The serial line is brought into the clk domain through a two-flop
// synchronizer. A mid-bit sampling state machine then assembles the byte.
// A completed byte is held with a level "valid" flag until the control
// block retires it. A low stop bit raises a sticky frame-error flag. The
// receiver then parks until the line returns high, so a line held low
// (break) cannot retrigger reception.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_rxd,
  uart_rx_core_if.master bus
);

  // Baud counter only has to reach CLKS_PER_BIT-1.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Start bit is checked half a bit in. Data and stop bits are then
  // sampled one full bit period apart, which puts them mid-bit as well.
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'd7;

  // Elaboration-time parameter sanity.
  if (DATA_BITS != 8) begin : g_data_bits_chk
    $error("uart_rx_core: DATA_BITS must be 8 in this revision");
  end
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_cpb_chk
    $error("uart_rx_core: CLKS_PER_BIT must be within 4..65535");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    sync_reg;
  logic          rxs;
  logic [CW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    rx_reg, rx_next;
  logic          send_reg, send_next;
  logic          irq_reg, irq_next;
  logic          busy_reg, busy_next;
  logic          ferr_reg, ferr_next;

  // Two-flop synchronizer. It resets to the idle (high) line level so
  // that reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], i_rxd};
    end
  end

  assign rxs = sync_reg[1];

  // State, counters, shift register and all output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      rx_reg    <= '0;
      send_reg  <= 1'b0;
      irq_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      rx_reg    <= rx_next;
      send_reg  <= send_next;
      irq_reg   <= irq_next;
      busy_reg  <= busy_next;
      ferr_reg  <= ferr_next;
    end
  end

  // Next-state and output decode. The finish pulse clears the pending
  // flags by default. A set in the same cycle overrides that clear,
  // because the set is assigned later in the block.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg + CW'(1);
    bit_next   = bit_reg;
    shift_next = shift_reg;
    rx_next    = rx_reg;
    send_next  = send_reg & ~bus.i_rx_finish;
    ferr_next  = ferr_reg & ~bus.i_rx_finish;
    irq_next   = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        // Level-triggered: any low synchronized sample starts a frame.
        baud_next = '0;
        if (!rxs) begin
          state_next = ST_START;
        end
      end

      ST_START: begin
        if (baud_reg == HALF_M1) begin
          baud_next = '0;
          if (rxs) begin
            // Line went back high before mid-start: a glitch, not a frame.
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DATA;
            bit_next   = '0;
          end
        end
      end

      ST_DATA: begin
        if (baud_reg == FULL_M1) begin
          baud_next  = '0;
          // Right shift: the first (LSB) sample ends up in bit 0.
          shift_next = {rxs, shift_reg[7:1]};
          if (bit_reg == LAST_BIT) begin
            state_next = ST_STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end

      ST_STOP: begin
        if (baud_reg == FULL_M1) begin
          baud_next = '0;
          if (rxs) begin
            // Good frame. An unread byte is simply overwritten. The
            // control block detects overrun from busy-while-full.
            rx_next    = shift_reg;
            send_next  = 1'b1;
            irq_next   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            // Bad stop bit: keep the previous byte and flag the error.
            ferr_next  = 1'b1;
            state_next = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        // Hold off until the line is released, so a long low (break)
        // does not look like a stream of start bits.
        baud_next = '0;
        if (rxs) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        baud_next  = '0;
        state_next = ST_IDLE;
      end
    endcase

    // Busy follows the frame-reception states and is registered alongside them.
    busy_next = (state_next == ST_START) ||
                (state_next == ST_DATA)  ||
                (state_next == ST_STOP);
  end

  assign bus.o_rx          = {24'h00_0000, rx_reg};
  assign bus.o_send_signal = send_reg;
  assign bus.o_irq         = irq_reg;
  assign bus.o_rx_busy     = busy_reg;
  assign bus.o_frame_err   = ferr_reg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at CLKS_PER_BIT=8.
// A frame-level reference predicts every output on every cycle. It works
// from sample instants computed as offsets from the detected start. It is
// pinned by hand-computed expectations after each directed scenario.
`timescale 1ns/1ps
module tb_uart_rx_core;
  localparam int CPB = 8;
  localparam int FRAME_CYC = 10 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;

  uart_rx_core_if bus();

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_rxd (rxd),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int shown = 0;
  int irq_cnt = 0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (shown < 40) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      shown++;
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 = waiting for low line, 1 = inside a frame, 2 = line held low after bad stop.
  logic [7:0] m_rx = 8'h00;
  logic m_send = 1'b0, m_irq = 1'b0, m_busy = 1'b0, m_ferr = 1'b0;
  logic m_bits [8];
  logic s1 = 1'b1, s2 = 1'b1;   // line as seen two clocks later
  int mode = 0, t0 = 0, cyc = 0, off = 0, k = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_rx = 8'h00; m_send = 1'b0; m_irq = 1'b0; m_busy = 1'b0; m_ferr = 1'b0;
        s1 = 1'b1; s2 = 1'b1; mode = 0; cyc = 0;
      end else begin
        m_irq = 1'b0;
        if (bus.i_rx_finish) begin
          m_send = 1'b0;
          m_ferr = 1'b0;
        end
        case (mode)
          0: if (!s2) begin mode = 1; t0 = cyc; m_busy = 1'b1; end
          1: begin
            off = cyc - t0;
            if (off == CPB / 2) begin
              if (s2) begin mode = 0; m_busy = 1'b0; end
            end else if (off > CPB / 2 && ((off - CPB / 2) % CPB) == 0) begin
              k = (off - CPB / 2) / CPB;   // 1..8 data bits, 9 = stop
              if (k <= 8) begin
                m_bits[k - 1] = s2;
              end else begin
                m_busy = 1'b0;
                if (s2) begin
                  for (int i = 0; i < 8; i++) m_rx[i] = m_bits[i];
                  m_send = 1'b1; m_irq = 1'b1; mode = 0;
                end else begin
                  m_ferr = 1'b1; mode = 2;
                end
              end
            end
          end
          default: if (s2) mode = 0;
        endcase
        s2 = s1;
        s1 = rxd;
        cyc++;
      end
    end
  end

  // Cycle-by-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("model_rx",        bus.o_rx,                 {24'h0, m_rx});
      check("model_send",      32'(bus.o_send_signal),   32'(m_send));
      check("model_irq",       32'(bus.o_irq),           32'(m_irq));
      check("model_busy",      32'(bus.o_rx_busy),       32'(m_busy));
      check("model_frame_err", 32'(bus.o_frame_err),     32'(m_ferr));
      if (bus.o_irq) irq_cnt++;
      if (bus.o_rx_busy) busy_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      rxd = 1'b1;
      bus.i_rx_finish = 1'b0;
    end
  endtask

  task automatic pulse_finish();
    tick();
    bus.i_rx_finish = 1'b1;
    tick();
    bus.i_rx_finish = 1'b0;
  endtask

  // One 8N1 frame; optional finish pulse, trailing low hold and reset window.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int finish_at,
                            input int low_hold, input int rst_at, input int rst_len);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int c = 0; c < FRAME_CYC; c++) begin
      tick();
      rxd = fr[c / CPB];
      bus.i_rx_finish = (c == finish_at);
      if (c == rst_at) rst_n = 1'b0;
      if (c == rst_at + rst_len) rst_n = 1'b1;
      if (rst_at >= 0 && c == rst_at + 2) begin
        check("rst_rx",   bus.o_rx, 32'h0);
        check("rst_send", 32'(bus.o_send_signal), 32'h0);
        check("rst_irq",  32'(bus.o_irq), 32'h0);
        check("rst_busy", 32'(bus.o_rx_busy), 32'h0);
        check("rst_ferr", 32'(bus.o_frame_err), 32'h0);
      end
    end
    for (int c = 0; c < low_hold; c++) begin
      tick();
      rxd = 1'b0;
      bus.i_rx_finish = 1'b0;
    end
  endtask

  initial begin
    bus.i_rx_finish = 1'b0;
    rxd = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_rx",   bus.o_rx, 32'h0);
    check("reset_send", 32'(bus.o_send_signal), 32'h0);
    check("reset_irq",  32'(bus.o_irq), 32'h0);
    check("reset_busy", 32'(bus.o_rx_busy), 32'h0);
    check("reset_ferr", 32'(bus.o_frame_err), 32'h0);
    rst_n = 1'b1;
    idle(4);

    // 1: good frame 0xA5
    irq_cnt = 0; busy_cnt = 0;
    send_frame(8'hA5, 1'b1, -1, 0, -1, 0);
    idle(4);
    check("t1_busy_cycles", busy_cnt, 32'd76);
    check("t1_irq_pulses",  irq_cnt, 32'd1);
    check("t1_rx",          bus.o_rx, 32'h0000_00A5);
    idle(10);
    check("t1_send_held",   32'(bus.o_send_signal), 32'h1);
    pulse_finish();
    check("t1_send_clr",    32'(bus.o_send_signal), 32'h0);
    check("t1_rx_kept",     bus.o_rx, 32'h0000_00A5);

    // 2: two-cycle glitch
    irq_cnt = 0; busy_cnt = 0;
    tick(); rxd = 1'b0;
    tick();
    tick(); rxd = 1'b1;
    idle(12);
    check("t2_busy_cycles", busy_cnt, 32'd4);
    check("t2_irq_pulses",  irq_cnt, 32'd0);
    check("t2_send",        32'(bus.o_send_signal), 32'h0);
    check("t2_ferr",        32'(bus.o_frame_err), 32'h0);

    // 3: 0x3C with low stop bit, line held low 40 more cycles
    irq_cnt = 0; busy_cnt = 0;
    send_frame(8'h3C, 1'b0, -1, 40, -1, 0);
    check("t3_ferr",        32'(bus.o_frame_err), 32'h1);
    check("t3_busy_in_brk", 32'(bus.o_rx_busy), 32'h0);
    check("t3_busy_cycles", busy_cnt, 32'd76);
    check("t3_irq_pulses",  irq_cnt, 32'd0);
    check("t3_rx_kept",     bus.o_rx, 32'h0000_00A5);
    idle(6);
    check("t3_ferr_held",   32'(bus.o_frame_err), 32'h1);
    pulse_finish();
    check("t3_ferr_clr",    32'(bus.o_frame_err), 32'h0);

    // 4: back-to-back 0x11, 0x22 without finish
    irq_cnt = 0;
    send_frame(8'h11, 1'b1, -1, 0, -1, 0);
    send_frame(8'h22, 1'b1, -1, 0, -1, 0);
    idle(4);
    check("t4_irq_pulses",  irq_cnt, 32'd2);
    check("t4_rx",          bus.o_rx, 32'h0000_0022);
    check("t4_send",        32'(bus.o_send_signal), 32'h1);
    pulse_finish();
    check("t4_send_clr",    32'(bus.o_send_signal), 32'h0);

    // 5: finish coincides with the 0x22 stop-bit sample
    send_frame(8'h11, 1'b1, -1, 0, -1, 0);
    send_frame(8'h22, 1'b1, FRAME_CYC - 2, 0, -1, 0);
    idle(4);
    check("t5_send_set_wins", 32'(bus.o_send_signal), 32'h1);
    check("t5_rx",            bus.o_rx, 32'h0000_0022);
    pulse_finish();

    // 6: reset in the middle of 0x55 data, then a clean 0x66
    irq_cnt = 0;
    send_frame(8'h55, 1'b1, -1, 0, 30, 44);
    idle(4);
    check("t6_rx_after_rst",  bus.o_rx, 32'h0);
    check("t6_irq_after_rst", irq_cnt, 32'd0);
    check("t6_ferr",          32'(bus.o_frame_err), 32'h0);
    send_frame(8'h66, 1'b1, -1, 0, -1, 0);
    idle(4);
    check("t6_rx",            bus.o_rx, 32'h0000_0066);
    check("t6_send",          32'(bus.o_send_signal), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
